evr_sequence_recorder: RTL and testbench

Receiver-side counterpart of the EVG sequencer. It watches the recovered event stream in the EVR receive clock domain and rebuilds the {gap, event} table that produced it. Each entry goes into an internal FIFO for readout. Diagnostics use it to capture a transmitted sequence and compare it against the table the EVG was loaded with.

---
 rtl/evr_seq_pkg.sv | 21 ++
 rtl/evr_sequence_recorder_if.sv | 14 +
 rtl/evr_entry_fifo.sv | 57 +++++
 rtl/evr_sequence_recorder.sv | 109 ++++++++++
 tb/tb_evr_sequence_recorder.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/evr_seq_pkg.sv
// Shared constants and types for the EVR sequence recorder: event codes,
// recorder state encoding and the {gap, event} entry layout.
package evr_seq_pkg;

  localparam int EVENTCODE_WIDTH_DEFAULT = 8;
  localparam int GAP_WIDTH_DEFAULT       = 28;
  localparam int FIFO_DEPTH_DEFAULT      = 512;

  localparam logic [7:0] END_OF_TABLE_EVENT_CODE = 8'h7F;
  localparam logic [7:0] NULL_EVENT_CODE         = 8'h00;

  // Entry word matches the EVG sequence RAM: event code in the low bits, gap above it.
  localparam int ENTRY_EVENT_LSB = 0;

  typedef enum logic [1:0] {
    STATE_IDLE      = 2'd0,
    STATE_ARMED     = 2'd1,
    STATE_RECORDING = 2'd2
  } recorderState_t;

endpackage

// File: rtl/evr_sequence_recorder_if.sv
// Entry readout stream of the sequence recorder, {gap, event} words toward the reader.
interface evr_sequence_recorder_if #(
  parameter int ENTRY_WIDTH = evr_seq_pkg::GAP_WIDTH_DEFAULT + evr_seq_pkg::EVENTCODE_WIDTH_DEFAULT
);
  // entryTVALID/entryTDATA hold steady until accepted; a transfer happens on
  // every rising edge where entryTVALID && entryTREADY, and the next head
  // shows up on the following cycle. entryTREADY may toggle freely.
  logic [ENTRY_WIDTH-1:0] entryTDATA;
  logic                   entryTVALID;
  logic                   entryTREADY;

  modport master (output entryTDATA, output entryTVALID, input entryTREADY);
  modport slave  (input entryTDATA, input entryTVALID, output entryTREADY);
endinterface

// File: rtl/evr_entry_fifo.sv
// Synchronous FIFO with a registered head word, occupancy count and full/empty flags.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module evr_entry_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pushValid,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     popReady,
  output logic [WIDTH-1:0]         headData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr, wrPtr, rdPtrNext;
  logic [CNT_W-1:0] countAfterPop, countNext;
  logic [WIDTH-1:0] headNext;
  logic             doPush, doPop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    doPop         = popReady && !empty;
    doPush        = pushValid && (!full || doPop);
    countAfterPop = count - CNT_W'(doPop);
    countNext     = countAfterPop + CNT_W'(doPush);
    rdPtrNext     = rdPtr + PTR_W'(doPop);
    // When nothing older remains, the incoming word lands directly in the head register.
    headNext      = (countAfterPop == '0) ? pushData : mem[rdPtrNext];
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      headData <= '0;
    end else begin
      rdPtr <= rdPtrNext;
      count <= countNext;
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop || doPush) headData <= headNext;
    end
  end

endmodule

// File: rtl/evr_sequence_recorder.sv
// Rebuilds the {gap, event} sequence table from the received event stream and
// queues each entry for readout; status exposes the recorder state and statistics.
module evr_sequence_recorder #(
  parameter int                         EVENTCODE_WIDTH         = evr_seq_pkg::EVENTCODE_WIDTH_DEFAULT,
  parameter int                         GAP_WIDTH               = evr_seq_pkg::GAP_WIDTH_DEFAULT,
  parameter int                         FIFO_DEPTH              = evr_seq_pkg::FIFO_DEPTH_DEFAULT,
  parameter logic [EVENTCODE_WIDTH-1:0] END_OF_TABLE_EVENT_CODE = evr_seq_pkg::END_OF_TABLE_EVENT_CODE
) (
  input  logic                        evrRxClk,
  input  logic                        evrRxReset,
  input  logic [EVENTCODE_WIDTH-1:0]  evrEventTDATA,
  input  logic                        evrEventTVALID,
  input  logic                        evrSequenceStart,
  input  logic                        armStrobe,
  input  logic                        disarmStrobe,
  evr_sequence_recorder_if.master     entry,
  output logic [$clog2(FIFO_DEPTH):0] entryCount,
  output logic [15:0]                 status
);
  import evr_seq_pkg::*;

  localparam int ENTRY_WIDTH = GAP_WIDTH + EVENTCODE_WIDTH;
  localparam int GAP_LSB     = ENTRY_EVENT_LSB + EVENTCODE_WIDTH;
  localparam logic [GAP_WIDTH-1:0] GAP_MAX = '1;

  recorderState_t          state, stateNext;
  logic [GAP_WIDTH-1:0]    gapCounter;
  logic [7:0]              overflowCount;
  logic                    overflowSticky, gapSaturated;
  logic                    eventHit, armAccept, startAccept, pushDropped;
  logic                    fifoFull, fifoEmpty;
  logic [ENTRY_WIDTH-1:0]  pushData, fifoHead;

  assign eventHit    = (state == STATE_RECORDING) && evrEventTVALID
                       && (evrEventTDATA != EVENTCODE_WIDTH'(NULL_EVENT_CODE));
  assign armAccept   = (state == STATE_IDLE) && armStrobe;
  assign startAccept = (state == STATE_ARMED) && evrSequenceStart && !disarmStrobe;
  // Full FIFO drops the entry unless the reader frees a slot this same cycle.
  assign pushDropped = eventHit && fifoFull && !entry.entryTREADY;

  always_comb begin
    pushData = '0;
    pushData[ENTRY_EVENT_LSB +: EVENTCODE_WIDTH] = evrEventTDATA;
    pushData[GAP_LSB +: GAP_WIDTH]               = gapCounter;
  end

  always_ff @(posedge evrRxClk) begin
    if (evrRxReset) state <= STATE_IDLE;
    else            state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      STATE_IDLE:      if (armStrobe) stateNext = STATE_ARMED;
      STATE_ARMED: begin
        if (disarmStrobe)          stateNext = STATE_IDLE;
        else if (evrSequenceStart) stateNext = STATE_RECORDING;
      end
      STATE_RECORDING: begin
        if (disarmStrobe || (eventHit && evrEventTDATA == END_OF_TABLE_EVENT_CODE))
          stateNext = STATE_IDLE;
      end
      default:         stateNext = STATE_IDLE;
    endcase
  end

  // Gap counts idle cycles since the start or the last recorded event.
  always_ff @(posedge evrRxClk) begin
    if (evrRxReset)                        gapCounter <= '0;
    else if (startAccept || eventHit)      gapCounter <= '0;
    else if (state == STATE_RECORDING && gapCounter != GAP_MAX)
      gapCounter <= gapCounter + GAP_WIDTH'(1);
  end

  always_ff @(posedge evrRxClk) begin
    if (evrRxReset || armAccept) begin
      overflowCount  <= '0;
      overflowSticky <= 1'b0;
      gapSaturated   <= 1'b0;
    end else begin
      if (eventHit && gapCounter == GAP_MAX) gapSaturated <= 1'b1;
      if (pushDropped) begin
        overflowSticky <= 1'b1;
        if (overflowCount != 8'hFF) overflowCount <= overflowCount + 8'd1;
      end
    end
  end

  evr_entry_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) entryFifo (
    .clk       (evrRxClk),
    .rst       (evrRxReset),
    .pushValid (eventHit),
    .pushData  (pushData),
    .popReady  (entry.entryTREADY),
    .headData  (fifoHead),
    .count     (entryCount),
    .full      (fifoFull),
    .empty     (fifoEmpty)
  );

  assign entry.entryTDATA  = fifoHead;
  assign entry.entryTVALID = !fifoEmpty;
  assign status = {state, gapSaturated, overflowSticky, 4'b0000, overflowCount};

endmodule

// File: tb/tb_evr_sequence_recorder.sv
// Directed bench: dutA uses the default geometry, dutB a 4-bit gap and 4-deep FIFO
// so saturation and overflow are reachable. Both share the stimulus inputs.
module tb_evr_sequence_recorder;

  logic       evrRxClk = 1'b0;
  logic       evrRxReset = 1'b1;
  logic [7:0] evrEventTDATA = '0;
  logic       evrEventTVALID = 1'b0;
  logic       evrSequenceStart = 1'b0;
  logic       armStrobe = 1'b0;
  logic       disarmStrobe = 1'b0;
  logic       entryTREADY = 1'b0;
  logic [9:0] countA;
  logic [2:0] countB;
  logic [15:0] statusA, statusB;
  int vectors = 0;
  int miscompares = 0;

  evr_sequence_recorder_if #(.ENTRY_WIDTH(36)) ifA ();
  evr_sequence_recorder_if #(.ENTRY_WIDTH(12)) ifB ();
  assign ifA.entryTREADY = entryTREADY;
  assign ifB.entryTREADY = entryTREADY;

  // ---- clock / reset
  always #5 evrRxClk = ~evrRxClk;

  evr_sequence_recorder dutA (
    .evrRxClk(evrRxClk), .evrRxReset(evrRxReset), .evrEventTDATA(evrEventTDATA),
    .evrEventTVALID(evrEventTVALID), .evrSequenceStart(evrSequenceStart),
    .armStrobe(armStrobe), .disarmStrobe(disarmStrobe), .entry(ifA),
    .entryCount(countA), .status(statusA)
  );

  evr_sequence_recorder #(.GAP_WIDTH(4), .FIFO_DEPTH(4)) dutB (
    .evrRxClk(evrRxClk), .evrRxReset(evrRxReset), .evrEventTDATA(evrEventTDATA),
    .evrEventTVALID(evrEventTVALID), .evrSequenceStart(evrSequenceStart),
    .armStrobe(armStrobe), .disarmStrobe(disarmStrobe), .entry(ifB),
    .entryCount(countB), .status(statusB)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---- driver tasks
  task automatic drive_cycle(input logic start, input logic arm, input logic disarm,
                             input logic valid, input logic [7:0] code);
    evrSequenceStart = start; armStrobe = arm; disarmStrobe = disarm;
    evrEventTVALID = valid; evrEventTDATA = code;
    @(posedge evrRxClk); #1;
    evrSequenceStart = 0; armStrobe = 0; disarmStrobe = 0;
    evrEventTVALID = 0; evrEventTDATA = '0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) drive_cycle(0, 0, 0, 0, 8'h00);
  endtask

  task automatic pop_one();
    entryTREADY = 1;
    @(posedge evrRxClk); #1;
    entryTREADY = 0;
  endtask

  task automatic apply_reset();
    evrRxReset = 1; entryTREADY = 0;
    repeat (2) @(posedge evrRxClk);
    #1 evrRxReset = 0;
  endtask

  // ---- scenarios
  task automatic test_reset();
    apply_reset();
    vectors++; if (countA !== 10'd0) begin miscompares++; $display("FAIL reset_countA: got %0d expected 0", countA); end
    vectors++; if (statusA !== 16'h0000) begin miscompares++; $display("FAIL reset_statusA: got %h expected 0000", statusA); end
    vectors++; if (ifA.entryTVALID !== 1'b0) begin miscompares++; $display("FAIL reset_validA: got %b expected 0", ifA.entryTVALID); end
    vectors++; if (ifA.entryTDATA !== 36'h0) begin miscompares++; $display("FAIL reset_dataA: got %h expected 0", ifA.entryTDATA); end
    vectors++; if (countB !== 3'd0 || statusB !== 16'h0000) begin miscompares++; $display("FAIL reset_B: got count %0d status %h expected 0/0000", countB, statusB); end
    pop_one();
    vectors++; if (countA !== 10'd0) begin miscompares++; $display("FAIL pop_empty: got %0d expected 0", countA); end
    drive_cycle(1, 0, 0, 0, 8'h00);
    vectors++; if (statusA !== 16'h0000) begin miscompares++; $display("FAIL start_in_idle: got %h expected 0000", statusA); end
  endtask

  task automatic test_basic_table();
    apply_reset();
    drive_cycle(0, 1, 0, 0, 8'h00);
    vectors++; if (statusA !== 16'h4000) begin miscompares++; $display("FAIL armed_state: got %h expected 4000", statusA); end
    drive_cycle(1, 0, 0, 0, 8'h00);
    drive_cycle(0, 0, 0, 1, 8'h10);
    drive_cycle(0, 0, 0, 1, 8'h11);
    idle_cycles(98);
    vectors++; if (statusA !== 16'h8000) begin miscompares++; $display("FAIL recording_state: got %h expected 8000", statusA); end
    drive_cycle(0, 0, 0, 1, 8'h7F);
    vectors++; if (statusA !== 16'h0000) begin miscompares++; $display("FAIL eot_idle: got %h expected 0000", statusA); end
    vectors++; if (countA !== 10'd3) begin miscompares++; $display("FAIL basic_count: got %0d expected 3", countA); end
    vectors++; if (ifA.entryTDATA !== {28'd0, 8'h10}) begin miscompares++; $display("FAIL basic_entry0: got %h expected %h", ifA.entryTDATA, {28'd0, 8'h10}); end
    pop_one();
    vectors++; if (ifA.entryTDATA !== {28'd0, 8'h11}) begin miscompares++; $display("FAIL basic_entry1: got %h expected %h", ifA.entryTDATA, {28'd0, 8'h11}); end
    pop_one();
    vectors++; if (ifA.entryTDATA !== {28'd98, 8'h7F}) begin miscompares++; $display("FAIL basic_entry2: got %h expected %h", ifA.entryTDATA, {28'd98, 8'h7F}); end
    pop_one();
    vectors++; if (ifA.entryTVALID !== 1'b0 || countA !== 10'd0) begin miscompares++; $display("FAIL basic_drained: got valid %b count %0d expected 0/0", ifA.entryTVALID, countA); end
  endtask

  task automatic test_disarm();
    apply_reset();
    drive_cycle(0, 1, 0, 0, 8'h00);
    drive_cycle(1, 0, 0, 0, 8'h00);
    idle_cycles(3);
    drive_cycle(0, 0, 1, 1, 8'h22);
    vectors++; if (statusA !== 16'h0000) begin miscompares++; $display("FAIL disarm_idle: got %h expected 0000", statusA); end
    drive_cycle(0, 0, 0, 1, 8'h23);
    vectors++; if (countA !== 10'd1) begin miscompares++; $display("FAIL disarm_count: got %0d expected 1", countA); end
    vectors++; if (ifA.entryTDATA !== {28'd3, 8'h22}) begin miscompares++; $display("FAIL disarm_entry: got %h expected %h", ifA.entryTDATA, {28'd3, 8'h22}); end
  endtask

  task automatic test_gap_saturation();
    apply_reset();
    drive_cycle(0, 1, 0, 0, 8'h00);
    drive_cycle(1, 0, 0, 0, 8'h00);
    idle_cycles(39);
    drive_cycle(0, 0, 0, 1, 8'h05);
    vectors++; if (ifB.entryTDATA !== 12'hF05) begin miscompares++; $display("FAIL sat_entry: got %h expected F05", ifB.entryTDATA); end
    vectors++; if (statusB !== 16'hA000) begin miscompares++; $display("FAIL sat_flag: got %h expected A000", statusB); end
    drive_cycle(0, 0, 1, 0, 8'h00);
    vectors++; if (statusB !== 16'h2000) begin miscompares++; $display("FAIL sat_sticky: got %h expected 2000", statusB); end
    drive_cycle(0, 1, 0, 0, 8'h00);
    vectors++; if (statusB !== 16'h4000) begin miscompares++; $display("FAIL sat_rearm_clear: got %h expected 4000", statusB); end
  endtask

  task automatic test_overflow();
    logic [7:0] codes[4];
    codes[0] = 8'h42; codes[1] = 8'h43; codes[2] = 8'h44; codes[3] = 8'h47;
    apply_reset();
    drive_cycle(0, 1, 0, 0, 8'h00);
    drive_cycle(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) drive_cycle(0, 0, 0, 1, 8'h41 + 8'(i));
    vectors++; if (countB !== 3'd4) begin miscompares++; $display("FAIL ovf_count: got %0d expected 4", countB); end
    vectors++; if (statusB !== 16'h9002) begin miscompares++; $display("FAIL ovf_status: got %h expected 9002", statusB); end
    vectors++; if (ifB.entryTDATA !== 12'h041) begin miscompares++; $display("FAIL ovf_head: got %h expected 041", ifB.entryTDATA); end
    entryTREADY = 1;
    drive_cycle(0, 0, 0, 1, 8'h47);
    entryTREADY = 0;
    vectors++; if (countB !== 3'd4) begin miscompares++; $display("FAIL full_push_pop_count: got %0d expected 4", countB); end
    vectors++; if (statusB !== 16'h9002) begin miscompares++; $display("FAIL full_push_pop_status: got %h expected 9002", statusB); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ifB.entryTDATA !== {4'h0, codes[i]}) begin
        miscompares++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, ifB.entryTDATA, {4'h0, codes[i]});
      end
      pop_one();
    end
    vectors++; if (countB !== 3'd0) begin miscompares++; $display("FAIL ovf_drained: got %0d expected 0", countB); end
  endtask

  task automatic test_start_and_null();
    apply_reset();
    drive_cycle(0, 1, 0, 0, 8'h00);
    drive_cycle(1, 0, 0, 1, 8'h30);
    vectors++; if (statusA !== 16'h8000 || countA !== 10'd0) begin miscompares++; $display("FAIL start_same_cycle: got status %h count %0d expected 8000/0", statusA, countA); end
    drive_cycle(0, 0, 0, 1, 8'h00);
    vectors++; if (countA !== 10'd0) begin miscompares++; $display("FAIL null_event: got %0d expected 0", countA); end
    idle_cycles(1);
    drive_cycle(0, 0, 0, 1, 8'h31);
    vectors++; if (ifA.entryTDATA !== {28'd2, 8'h31}) begin miscompares++; $display("FAIL null_gap: got %h expected %h", ifA.entryTDATA, {28'd2, 8'h31}); end
    drive_cycle(0, 1, 0, 0, 8'h00);
    vectors++; if (statusA !== 16'h8000) begin miscompares++; $display("FAIL arm_in_recording: got %h expected 8000", statusA); end
  endtask

  task automatic test_reset_mid_capture();
    apply_reset();
    drive_cycle(0, 1, 0, 0, 8'h00);
    drive_cycle(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 1, 8'h51 + 8'(i));
    vectors++; if (countA !== 10'd3) begin miscompares++; $display("FAIL mid_count: got %0d expected 3", countA); end
    evrRxReset = 1;
    @(posedge evrRxClk); #1;
    evrRxReset = 0;
    vectors++; if (statusA !== 16'h0000) begin miscompares++; $display("FAIL mid_reset_status: got %h expected 0000", statusA); end
    vectors++; if (ifA.entryTVALID !== 1'b0 || countA !== 10'd0) begin miscompares++; $display("FAIL mid_reset_fifo: got valid %b count %0d expected 0/0", ifA.entryTVALID, countA); end
    vectors++; if (ifA.entryTDATA !== 36'h0) begin miscompares++; $display("FAIL mid_reset_data: got %h expected 0", ifA.entryTDATA); end
  endtask

  // ---- sequence and report
  initial begin
    test_reset();
    test_basic_table();
    test_disarm();
    test_gap_saturation();
    test_overflow();
    test_start_and_null();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
